// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Takes one quotient bit per cycle and handles divide-by-zero and signed overflow without iterating.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic            is_rem;
    logic            sign_a;
    logic            sign_b;
    logic            special;

    logic            op_valid;
    logic            accept;
    logic            b_zero;
    logic            overflow;
    logic            op_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   rem_shift;
    logic            trial_ok;
    logic [XLEN-1:0] trial;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;

    // Request decode and the single restoring-division step
    always_comb begin
        op_valid  = (alu_control[4:2] == 3'b011);
        op_signed = alu_control[0];
        accept    = (state == IDLE) && start && !flush && op_valid;
        b_zero    = (operand_b == '0);
        overflow  = op_signed && (operand_a == MIN_NEG) && (operand_b == '1);
        abs_a     = (op_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
        abs_b     = (op_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;
        rem_shift = {rem, quo[XLEN-1]};
        trial_ok  = (rem_shift >= {1'b0, divisor});
        // When trial_ok holds the difference is below the divisor, so the low bits are exact
        trial     = rem_shift[XLEN-1:0] - divisor;
        quo_fin   = quo;
        rem_fin   = rem;
        if (!special) begin
            if (sign_a ^ sign_b) begin
                quo_fin = -quo;
            end
            if (sign_a) begin
                rem_fin = -rem;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (b_zero || overflow) ? FINISH : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count == CW'(XLEN-1)) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: quo doubles as the dividend shift register while iterating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            is_rem  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            special <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem  <= alu_control[1];
                        sign_a  <= op_signed & operand_a[XLEN-1];
                        sign_b  <= op_signed & operand_b[XLEN-1];
                        divisor <= abs_b;
                        count   <= '0;
                        busy    <= 1'b1;
                        special <= b_zero | overflow;
                        if (b_zero) begin
                            quo <= '1;
                            rem <= operand_a;
                        end else if (overflow) begin
                            quo <= MIN_NEG;
                            rem <= '0;
                        end else begin
                            quo <= abs_a;
                            rem <= '0;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy <= 1'b0;
                    end else begin
                        rem   <= trial_ok ? trial : rem_shift[XLEN-1:0];
                        quo   <= {quo[XLEN-2:0], trial_ok};
                        count <= count + 1'b1;
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    if (!flush) begin
                        result <= is_rem ? rem_fin : quo_fin;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
